// File: rtl/fmc_test_pkg.sv
// FMC loopback tester shared types and constants.
// Optional sticky per-pin mask build: FMC_STICKY_MASK_EN.
package fmc_test_pkg;

  typedef enum logic [1:0] {
    FMC_TOGGLE,
    FMC_WALK1,
    FMC_WALK0,
    FMC_PRBS7
  } fmc_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } fmc_state_e;

  localparam int TOGGLE_STEPS = 16;
  localparam int PRBS7_STEPS  = 127;
  localparam logic [6:0] PRBS7_SEED = 7'h01;

  // x^7 + x^6 + 1, shift left, feedback into bit 0
  function automatic logic [6:0] prbs7_next(
    input logic [6:0] s
  );
    return {s[5:0], s[6] ^ s[5]};
  endfunction

endpackage

// File: rtl/fmc_loopback_tester_if.sv
// Control, status and pad bundle of the FMC loopback tester.
// err_mask exists only when FMC_STICKY_MASK_EN is defined.
interface fmc_loopback_tester_if
  import fmc_test_pkg::*;
#(
  parameter int NUM_PINS = 64,
  parameter int ERR_W    = 16,
  parameter int PIN_W    = $clog2(NUM_PINS)
) ();

  logic                start;
  fmc_mode_e           mode;
  logic [NUM_PINS-1:0] tx_pins;
  logic [NUM_PINS-1:0] rx_pins;
  logic                busy;
  logic                done;
  logic                pass;
  logic [ERR_W-1:0]    err_count;
  logic                first_err_valid;
  logic [PIN_W-1:0]    first_err_pin;
`ifdef FMC_STICKY_MASK_EN
  logic [NUM_PINS-1:0] err_mask;
`endif

  modport master (
    input  start, mode, rx_pins,
`ifdef FMC_STICKY_MASK_EN
    output err_mask,
`endif
    output tx_pins, busy, done, pass,
    output err_count,
    output first_err_valid, first_err_pin
  );

  modport slave (
    output start, mode, rx_pins,
`ifdef FMC_STICKY_MASK_EN
    input  err_mask,
`endif
    input  tx_pins, busy, done, pass,
    input  err_count,
    input  first_err_valid, first_err_pin
  );

endinterface

// File: rtl/fmc_pattern_step.sv
// Combinational test pattern for one step of the FMC pin test.
// Pure function of mode, step index and LFSR state.
module fmc_pattern_step
  import fmc_test_pkg::*;
#(
  parameter int NUM_PINS = 64,
  parameter int STEP_W   = 7
) (
  input  fmc_mode_e           mode,
  input  logic [STEP_W-1:0]   step,
  input  logic [6:0]          lfsr,
  output logic [NUM_PINS-1:0] tx
);

  logic [NUM_PINS-1:0] onehot;
  logic [NUM_PINS-1:0] prbs;

  // walking bit and replicated LFSR vectors
  always_comb begin
    onehot = '0;
    prbs   = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      onehot[i] = (step == STEP_W'(i));
      prbs[i]   = lfsr[i % 7];
    end
  end

  // select pattern by mode
  always_comb begin
    tx = '0;
    unique case (mode)
      FMC_TOGGLE: tx = {NUM_PINS{step[0]}};
      FMC_WALK1:  tx = onehot;
      FMC_WALK0:  tx = ~onehot;
      FMC_PRBS7:  tx = prbs;
      default:    tx = '0;
    endcase
  end

endmodule

// File: rtl/fmc_loopback_tester.sv
// FMC pin loopback tester: stepped pattern out, synced compare in.
// Optional sticky per-pin mask build: FMC_STICKY_MASK_EN.
module fmc_loopback_tester
  import fmc_test_pkg::*;
#(
  parameter int NUM_PINS = 64,
  parameter int DWELL    = 16,
  parameter int ERR_W    = 16,
  parameter int PIN_W    = $clog2(NUM_PINS)
) (
  input logic clock,
  input logic reset_n,
  fmc_loopback_tester_if.master bus
);

  localparam int MAX_STEPS =
    (NUM_PINS > PRBS7_STEPS) ? NUM_PINS : PRBS7_STEPS;
  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam int DW_W   = $clog2(DWELL);
  localparam int CNT_W  = $clog2(NUM_PINS + 1);
  localparam int SUM_W  =
    ((ERR_W > CNT_W) ? ERR_W : CNT_W) + 1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  fmc_state_e          state_q, state_d;
  fmc_mode_e           mode_q, mode_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [DW_W-1:0]     dwell_q, dwell_d;
  logic [6:0]          lfsr_q, lfsr_d;
  logic [NUM_PINS-1:0] tx_q, tx_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                fev_q, fev_d;
  logic [PIN_W-1:0]    fep_q, fep_d;
  logic [NUM_PINS-1:0] sync1_q, sync2_q;
`ifdef FMC_STICKY_MASK_EN
  logic [NUM_PINS-1:0] mask_q, mask_d;
`endif

  logic                start_ok;
  logic                sample;
  logic                last;
  logic [STEP_W-1:0]   last_step;
  logic [NUM_PINS-1:0] mis;
  logic [CNT_W-1:0]    pop;
  logic [PIN_W-1:0]    low_pin;
  logic [SUM_W-1:0]    sum;

  fmc_mode_e           pat_mode;
  logic [STEP_W-1:0]   pat_step;
  logic [6:0]          pat_lfsr;
  logic [NUM_PINS-1:0] pat_tx;

  fmc_pattern_step #(
    .NUM_PINS (NUM_PINS),
    .STEP_W   (STEP_W)
  ) u_pat (
    .mode (pat_mode),
    .step (pat_step),
    .lfsr (pat_lfsr),
    .tx   (pat_tx)
  );

  // step timing, compare vector and its reductions
  always_comb begin
    start_ok = bus.start && (state_q != ST_RUN);
    sample   = (state_q == ST_RUN) &&
               (dwell_q == DW_W'(DWELL - 1));
    last_step = '0;
    unique case (mode_q)
      FMC_TOGGLE: last_step = STEP_W'(TOGGLE_STEPS - 1);
      FMC_WALK1:  last_step = STEP_W'(NUM_PINS - 1);
      FMC_WALK0:  last_step = STEP_W'(NUM_PINS - 1);
      FMC_PRBS7:  last_step = STEP_W'(PRBS7_STEPS - 1);
      default:    last_step = '0;
    endcase
    last    = (step_q == last_step);
    mis     = sync2_q ^ tx_q;
    pop     = '0;
    low_pin = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      pop = pop + CNT_W'(mis[i]);
    end
    for (int i = NUM_PINS - 1; i >= 0; i--) begin
      if (mis[i]) low_pin = PIN_W'(i);
    end
    sum = SUM_W'(err_q) + SUM_W'(pop);
  end

  // pattern generator feeds either step 0 or the next step
  always_comb begin
    pat_mode = mode_q;
    pat_step = step_q + STEP_W'(1);
    pat_lfsr = prbs7_next(lfsr_q);
    if (start_ok) begin
      pat_mode = bus.mode;
      pat_step = '0;
      pat_lfsr = PRBS7_SEED;
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (sample && last) state_d = ST_DONE;
      ST_DONE: if (bus.start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // datapath next values
  always_comb begin
    mode_d  = mode_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    lfsr_d  = lfsr_q;
    tx_d    = tx_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fep_d   = fep_q;
`ifdef FMC_STICKY_MASK_EN
    mask_d  = mask_q;
`endif
    if (start_ok) begin
      mode_d  = bus.mode;
      step_d  = '0;
      dwell_d = '0;
      lfsr_d  = PRBS7_SEED;
      tx_d    = pat_tx;
      err_d   = '0;
      fev_d   = 1'b0;
      fep_d   = '0;
`ifdef FMC_STICKY_MASK_EN
      mask_d  = '0;
`endif
    end else if (state_q == ST_RUN) begin
      dwell_d = sample ? '0 : dwell_q + DW_W'(1);
      if (sample) begin
        err_d = (sum > SUM_W'(ERR_MAX)) ?
                ERR_MAX : sum[ERR_W-1:0];
        if (|mis && !fev_q) begin
          fev_d = 1'b1;
          fep_d = low_pin;
        end
`ifdef FMC_STICKY_MASK_EN
        mask_d = mask_q | mis;
`endif
        if (last) begin
          tx_d = '0;
        end else begin
          step_d = step_q + STEP_W'(1);
          lfsr_d = prbs7_next(lfsr_q);
          tx_d   = pat_tx;
        end
      end
    end
  end

  // datapath registers and rx synchroniser
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= FMC_TOGGLE;
      step_q  <= '0;
      dwell_q <= '0;
      lfsr_q  <= PRBS7_SEED;
      tx_q    <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fep_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
`ifdef FMC_STICKY_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      mode_q  <= mode_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      lfsr_q  <= lfsr_d;
      tx_q    <= tx_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fep_q   <= fep_d;
      sync1_q <= bus.rx_pins;
      sync2_q <= sync1_q;
`ifdef FMC_STICKY_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  // outputs decoded from state and registers
  always_comb begin
    bus.tx_pins         = tx_q;
    bus.busy            = (state_q == ST_RUN);
    bus.done            = (state_q == ST_DONE);
    bus.pass            = (state_q == ST_DONE) &&
                          (err_q == '0);
    bus.err_count       = err_q;
    bus.first_err_valid = fev_q;
    bus.first_err_pin   = fep_q;
`ifdef FMC_STICKY_MASK_EN
    bus.err_mask        = mask_q;
`endif
  end

endmodule

// File: tb/tb_fmc_loopback_tester.sv
// Directed bench for fmc_loopback_tester, 8 pins, dwell 16.
// Second instance with a 4-bit counter exercises saturation.
module tb_fmc_loopback_tester;
  import fmc_test_pkg::*;

  localparam int NP = 8;
  localparam int DW = 16;

  logic clock;
  logic reset_n;

  fmc_loopback_tester_if #(.NUM_PINS(NP), .ERR_W(16)) bus ();
  fmc_loopback_tester_if #(.NUM_PINS(NP), .ERR_W(4))  bus_s ();

  fmc_loopback_tester #(
    .NUM_PINS (NP),
    .DWELL    (DW),
    .ERR_W    (16)
  ) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  fmc_loopback_tester #(
    .NUM_PINS (NP),
    .DWELL    (DW),
    .ERR_W    (4)
  ) u_sat (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [NP-1:0] stuck0;
  logic [NP-1:0] inv;
  logic          short12;
  logic [NP-1:0] rx;

  // pad fault model between tx and rx
  always_comb begin
    rx = (bus.tx_pins & ~stuck0) ^ inv;
    if (short12) begin
      rx[1] = bus.tx_pins[1] & bus.tx_pins[2];
      rx[2] = bus.tx_pins[1] & bus.tx_pins[2];
    end
    bus.rx_pins = rx;
  end

  assign bus_s.rx_pins = ~bus_s.tx_pins;

  int n_vec = 0;
  int n_bad = 0;
  logic [NP-1:0] snap [0:255];
  int cyc;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_mode(
    input  fmc_mode_e m,
    input  int        poke,
    output int        c
  );
    int n;
    bus.mode  = m;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 4000) begin
      if (n % DW == 8) snap[n / DW] = bus.tx_pins;
      bus.start = (n == poke);
      if (n == poke) bus.mode = FMC_TOGGLE;
      n++;
      tick();
    end
    bus.start = 1'b0;
    c = n;
  endtask

  task automatic clr_faults();
    stuck0  = '0;
    inv     = '0;
    short12 = 1'b0;
  endtask

  initial begin
    int n;
    clr_faults();
    reset_n     = 1'b0;
    bus.start   = 1'b0;
    bus.mode    = FMC_TOGGLE;
    bus_s.start = 1'b0;
    bus_s.mode  = FMC_TOGGLE;
    tick();
    tick();
    chk("rst_tx",   32'(bus.tx_pins), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_pass", 32'(bus.pass), 32'h0);
    chk("rst_err",  32'(bus.err_count), 32'h0);
    chk("rst_fev",  32'(bus.first_err_valid), 32'h0);
    chk("rst_fep",  32'(bus.first_err_pin), 32'h0);
    reset_n = 1'b1;
    tick();

    run_mode(FMC_WALK1, -1, cyc);
    chk("w1_cyc",  32'(cyc), 32'd128);
    chk("w1_done", 32'(bus.done), 32'h1);
    chk("w1_pass", 32'(bus.pass), 32'h1);
    chk("w1_err",  32'(bus.err_count), 32'h0);
    chk("w1_fev",  32'(bus.first_err_valid), 32'h0);
    chk("w1_s3",   32'(snap[3]), 32'h08);
    chk("w1_s7",   32'(snap[7]), 32'h80);
    chk("w1_txd",  32'(bus.tx_pins), 32'h0);

    stuck0 = 8'h08;
    run_mode(FMC_WALK1, -1, cyc);
    chk("st3_err",  32'(bus.err_count), 32'd1);
    chk("st3_fev",  32'(bus.first_err_valid), 32'h1);
    chk("st3_fep",  32'(bus.first_err_pin), 32'd3);
    chk("st3_pass", 32'(bus.pass), 32'h0);
`ifdef FMC_STICKY_MASK_EN
    chk("st3_mask", 32'(bus.err_mask), 32'h08);
`endif
    clr_faults();

    inv = 8'h20;
    run_mode(FMC_TOGGLE, -1, cyc);
    chk("tg_cyc", 32'(cyc), 32'd256);
    chk("tg_err", 32'(bus.err_count), 32'd16);
    chk("tg_fep", 32'(bus.first_err_pin), 32'd5);
    chk("tg_s0",  32'(snap[0]), 32'h00);
    chk("tg_s1",  32'(snap[1]), 32'hFF);
    clr_faults();

    short12 = 1'b1;
    run_mode(FMC_WALK0, -1, cyc);
    chk("w0_err", 32'(bus.err_count), 32'd2);
    chk("w0_fep", 32'(bus.first_err_pin), 32'd2);
    chk("w0_s1",  32'(snap[1]), 32'hFD);
    clr_faults();

    run_mode(FMC_PRBS7, -1, cyc);
    chk("pr_cyc",  32'(cyc), 32'd2032);
    chk("pr_err",  32'(bus.err_count), 32'h0);
    chk("pr_pass", 32'(bus.pass), 32'h1);
    chk("pr_s0",   32'(snap[0]), 32'h81);
    chk("pr_s1",   32'(snap[1]), 32'h02);
    chk("pr_s2",   32'(snap[2]), 32'h04);

    run_mode(FMC_WALK1, 40, cyc);
    chk("poke_cyc", 32'(cyc), 32'd128);
    chk("poke_s5",  32'(snap[5]), 32'h20);
    chk("poke_err", 32'(bus.err_count), 32'h0);

    stuck0     = 8'h01;
    bus.mode   = FMC_WALK1;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    repeat (49) tick();
    chk("mid_err", 32'(bus.err_count), 32'd1);
    reset_n = 1'b0;
    tick();
    chk("mr_busy", 32'(bus.busy), 32'h0);
    chk("mr_done", 32'(bus.done), 32'h0);
    chk("mr_tx",   32'(bus.tx_pins), 32'h0);
    chk("mr_err",  32'(bus.err_count), 32'h0);
    chk("mr_fev",  32'(bus.first_err_valid), 32'h0);
    chk("mr_fep",  32'(bus.first_err_pin), 32'h0);
    reset_n = 1'b1;
    clr_faults();
    tick();

    bus_s.mode  = FMC_TOGGLE;
    bus_s.start = 1'b1;
    tick();
    bus_s.start = 1'b0;
    repeat (40) tick();
    chk("sat_mid", 32'(bus_s.err_count), 32'hF);
    n = 40;
    while (bus_s.busy && n < 1000) begin
      n++;
      tick();
    end
    chk("sat_cyc",  32'(n), 32'd256);
    chk("sat_err",  32'(bus_s.err_count), 32'hF);
    chk("sat_pass", 32'(bus_s.pass), 32'h0);
    chk("sat_done", 32'(bus_s.done), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
